// File: rtl/spi_slave_wrapper_pkg.sv
// Shared register map, status/ctrl bit positions and shifter state type
// for the SPI target and its bus wrapper.
package spi_slave_wrapper_pkg;

    // Register window (2-bit address)
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;

    // Status byte bit positions
    localparam int ST_RX_FULL   = 7;
    localparam int ST_TX_EMPTY  = 6;
    localparam int ST_OVERRUN   = 5;
    localparam int ST_UNDERRUN  = 4;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_CS_ACTIVE = 2;

    // Control byte bit positions
    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
    localparam int CTRL_CLR   = 7;

    // Byte shifted out when the master clocks a byte we have nothing for
    localparam logic [7:0] TX_FILL = 8'hFF;

    typedef enum logic {
        SH_IDLE   = 1'b0,
        SH_ACTIVE = 1'b1
    } shift_state_t;

    function automatic logic [7:0] pack_status(
        input logic       rx_full,
        input logic       tx_empty,
        input logic       overrun,
        input logic       underrun,
        input logic       frame_err,
        input logic       cs_active,
        input logic [1:0] ctrl
    );
        logic [7:0] s;
        s               = 8'h00;
        s[ST_RX_FULL]   = rx_full;
        s[ST_TX_EMPTY]  = tx_empty;
        s[ST_OVERRUN]   = overrun;
        s[ST_UNDERRUN]  = underrun;
        s[ST_FRAME_ERR] = frame_err;
        s[ST_CS_ACTIVE] = cs_active;
        s[CTRL_TX_IE]   = ctrl[CTRL_TX_IE];
        s[CTRL_RX_IE]   = ctrl[CTRL_RX_IE];
        return s;
    endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI target shifter: synchronises the external SPI pins into clk, finds
// SCLK edges, runs the IDLE/ACTIVE frame FSM and shifts bytes MSB-first.
// Hands completed bytes and TX-load requests to the wrapper as pulses.
module spi_slave_shifter
    import spi_slave_wrapper_pkg::*;
#(
    parameter logic CPOL     = 1'b0,
    parameter logic CPHA     = 1'b0,
    parameter int   SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       spi_cs_n,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       frame_err,
    output logic       cs_active,
    output logic       miso,
    output logic       miso_oe
);

    logic [SYNC_LEN-1:0] sclk_sync;
    logic [SYNC_LEN-1:0] mosi_sync;
    logic [SYNC_LEN-1:0] csn_sync;
    logic                sclk_d;
    logic                sclk_s;
    logic                mosi_s;
    logic                csn_s;
    logic                lead_edge;
    logic                trail_edge;
    logic                sample_edge;
    logic                shift_edge;

    shift_state_t        state;
    shift_state_t        state_nxt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift_rx;
    logic [7:0]          shift_tx;

    // Synchronise the asynchronous SPI pins; sclk gets one extra flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= {SYNC_LEN{CPOL}};
            mosi_sync <= '0;
            csn_sync  <= '1;
            sclk_d    <= CPOL;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_LEN-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_LEN-2:0], mosi};
            csn_sync  <= {csn_sync[SYNC_LEN-2:0], spi_cs_n};
            sclk_d    <= sclk_sync[SYNC_LEN-1];
        end
    end

    assign sclk_s      = sclk_sync[SYNC_LEN-1];
    assign mosi_s      = mosi_sync[SYNC_LEN-1];
    assign csn_s       = csn_sync[SYNC_LEN-1];
    // Leading edge leaves the idle level, trailing edge returns to it
    assign lead_edge   = (sclk_s != sclk_d) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign rx_byte     = {shift_rx[6:0], mosi_s};
    assign cs_active   = (state == SH_ACTIVE);

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state and the per-cycle event pulses to the wrapper
    always_comb begin
        state_nxt = state;
        tx_load   = 1'b0;
        rx_valid  = 1'b0;
        frame_err = 1'b0;
        case (state)
            SH_IDLE: begin
                if (!csn_s) begin
                    state_nxt = SH_ACTIVE;
                    tx_load   = 1'b1;
                end
            end
            SH_ACTIVE: begin
                if (csn_s) begin
                    state_nxt = SH_IDLE;
                    frame_err = (bit_cnt != 3'd0);
                end else if (sample_edge && (bit_cnt == 3'd7)) begin
                    rx_valid = 1'b1;
                    tx_load  = 1'b1;
                end
            end
        endcase
    end

    // Bit counter, shift registers and MISO driver
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= 3'd0;
            shift_rx <= 8'h00;
            shift_tx <= 8'h00;
            miso     <= 1'b1;
            miso_oe  <= 1'b0;
        end else begin
            case (state)
                SH_IDLE: begin
                    if (!csn_s) begin
                        bit_cnt  <= 3'd0;
                        shift_tx <= tx_byte;
                        miso_oe  <= 1'b1;
                        // With CPHA=0 the master samples before any shift edge
                        if (!CPHA) begin
                            miso <= tx_byte[7];
                        end
                    end
                end
                SH_ACTIVE: begin
                    if (csn_s) begin
                        bit_cnt <= 3'd0;
                        miso_oe <= 1'b0;
                        miso    <= 1'b1;
                    end else begin
                        if (sample_edge) begin
                            shift_rx <= {shift_rx[6:0], mosi_s};
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        if (tx_load) begin
                            shift_tx <= tx_byte;
                        end
                        // shift_tx is never shifted; the bit count picks the outgoing bit
                        // (bit_cnt wraps to 0 after a byte, selecting bit 7 of the next one)
                        if (shift_edge) begin
                            miso <= shift_tx[~bit_cnt];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_wrapper.sv
// CPU-addressable SPI target: 2-bit register window on the 6502 bus holding
// the RX/TX byte buffers, error flags, interrupt enables and a level IRQ.
module spi_slave_wrapper
    import spi_slave_wrapper_pkg::*;
#(
    parameter logic CPOL     = 1'b0,
    parameter logic CPHA     = 1'b0,
    parameter int   SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       spi_cs_n,
    output logic       miso,
    output logic       miso_oe
);

    logic [7:0] rx_data;
    logic [7:0] tx_hold;
    logic [1:0] ctrl;
    logic       rx_full;
    logic       tx_empty;
    logic       overrun;
    logic       underrun;
    logic       frame_err;

    logic       rd_data;
    logic       wr_data;
    logic       wr_stat;
    logic       clr_flags;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_load;
    logic       frame_abort;
    logic       cs_active;
    logic [7:0] tx_byte;

    assign rd_data   = cs && !we && (addr == ADDR_DATA);
    assign wr_data   = cs &&  we && (addr == ADDR_DATA);
    assign wr_stat   = cs &&  we && (addr == ADDR_STAT);
    assign clr_flags = wr_stat && din[CTRL_CLR];
    // A load always sees the pre-write hold register, so a same-cycle write is kept for the next byte
    assign tx_byte   = tx_empty ? TX_FILL : tx_hold;

    spi_slave_shifter #(
        .CPOL     (CPOL),
        .CPHA     (CPHA),
        .SYNC_LEN (SYNC_LEN)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .spi_cs_n  (spi_cs_n),
        .tx_byte   (tx_byte),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_load   (tx_load),
        .frame_err (frame_abort),
        .cs_active (cs_active),
        .miso      (miso),
        .miso_oe   (miso_oe)
    );

    // RX buffer: a byte arriving as the CPU reads the old one is accepted, otherwise a full buffer overruns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data <= 8'h00;
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (rx_valid && (!rx_full || rd_data)) begin
                rx_data <= rx_byte;
                rx_full <= 1'b1;
            end else if (rd_data) begin
                rx_full <= 1'b0;
            end
            if (rx_valid && rx_full && !rd_data) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end

    // TX hold register: CPU write wins over the shifter emptying it in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_hold  <= 8'h00;
            tx_empty <= 1'b1;
            underrun <= 1'b0;
        end else begin
            if (wr_data) begin
                tx_hold  <= din;
                tx_empty <= 1'b0;
            end else if (tx_load) begin
                tx_empty <= 1'b1;
            end
            if (tx_load && tx_empty) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

    // Interrupt enables and the aborted-frame flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl      <= 2'b00;
            frame_err <= 1'b0;
        end else begin
            if (wr_stat) begin
                ctrl <= din[1:0];
            end
            if (frame_abort) begin
                frame_err <= 1'b1;
            end else if (clr_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 8'h00;
        end else if (cs && !we) begin
            case (addr)
                ADDR_DATA: dout <= rx_data;
                ADDR_STAT: dout <= pack_status(rx_full, tx_empty, overrun, underrun,
                                               frame_err, cs_active, ctrl);
                default:   dout <= 8'h00;
            endcase
        end
    end

    // Level interrupt: enabled buffer conditions plus the unmaskable error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[CTRL_RX_IE] && rx_full) || (ctrl[CTRL_TX_IE] && tx_empty) ||
                   overrun || frame_err;
        end
    end

endmodule
